i2c_master_arbiter: RTL and testbench

//  Shares the single-byte I2C master (i2cM) between NUM_REQ independent requesters.

---
 rtl/i2c_master_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares one single-byte I2C master between NUM_REQ requesters.
// Each grant runs one complete transfer through the master's req / apb_data_valid /
// ready_busyBar handshake. The requester gets read data and a one-cycle done pulse.
// Optional watchdog: define I2C_ARB_TIMEOUT_EN to abort stuck transfers with rq_err=1.
module i2c_master_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               rq_valid,
  input  logic [NUM_REQ-1:0]               rq_wr_rdBar,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    rq_wdata,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    rq_addr,
  output logic [NUM_REQ-1:0]               rq_done,
  output logic                             rq_err,
  output logic [DATA_WIDTH-1:0]            rq_rdata,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  output logic [ADDR_WIDTH-1:0]            m_target_addr,
  output logic                             m_wr_rdBar,
  output logic                             m_apb_data_valid,
  output logic                             m_req,
  input  logic [DATA_WIDTH-1:0]            m_rdata,
  input  logic                             m_data_valid,
  input  logic                             m_ready_busyBar
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535)
  begin : g_bad_param
    $error("i2c_master_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {StIdle, StIssue, StWaitBusy, StWaitDone, StResp} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]         gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    wr_q, wr_d;
  logic                    strobe_q, strobe_d;
  logic                    pick_found;
  logic [IdxW-1:0]         pick_idx;
`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0]             cnt_q, cnt_d;
  logic                    err_q, err_d;
`endif

  // Round-robin pick: first valid requester scanning upward from rr_ptr, wrapping.
  always_comb begin
    int unsigned cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!pick_found && rq_valid[cand[IdxW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IdxW-1:0];
      end
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wr_q     <= 1'b0;
      strobe_q <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wr_q     <= wr_d;
      strobe_q <= strobe_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Next-state and payload capture.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    wr_d     = wr_q;
    strobe_d = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          addr_d  = rq_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = rq_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          wr_d    = rq_wr_rdBar[pick_idx];
          rdata_d = '0;
`ifdef I2C_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Strobe is registered, so it appears for one cycle on entry to WaitBusy.
        if (m_ready_busyBar) begin
          strobe_d = 1'b1;
          state_d  = StWaitBusy;
`ifdef I2C_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      StWaitBusy: begin
        if (!m_ready_busyBar) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (m_data_valid && !wr_q) rdata_d = m_rdata;
        if (m_ready_busyBar) state_d = StResp;
      end
      StResp: begin
        rr_ptr_d = (gnt_q == IdxW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog overrides the wait states once the limit is reached.
    if (state_q == StWaitBusy || state_q == StWaitDone) begin
      if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
        state_d = StResp;
        err_d   = 1'b1;
        rdata_d = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
`endif
  end

  // Outputs: payload to the master outside Idle, done pulse in Resp.
  always_comb begin
    rq_done       = '0;
    rq_err        = 1'b0;
    m_wdata       = '0;
    m_target_addr = '0;
    m_wr_rdBar    = 1'b0;
    if (state_q != StIdle) begin
      m_wdata       = wdata_q;
      m_target_addr = addr_q;
      m_wr_rdBar    = wr_q;
    end
    if (state_q == StResp) begin
      rq_done[gnt_q] = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
      rq_err = err_q;
`endif
    end
  end

  assign m_req            = strobe_q;
  assign m_apb_data_valid = strobe_q;
  assign rq_rdata         = rdata_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: behavioural I2C master, transaction-level round-robin
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_i2c_master_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    rq_valid, rq_wr_rdBar, rq_done;
  logic [N*DW-1:0] rq_wdata;
  logic [N*AW-1:0] rq_addr;
  logic            rq_err;
  logic [DW-1:0]   rq_rdata, m_wdata, m_rdata;
  logic [AW-1:0]   m_target_addr;
  logic            m_wr_rdBar, m_apb_data_valid, m_req, m_data_valid, m_ready_busyBar;

  i2c_master_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .rq_valid(rq_valid), .rq_wr_rdBar(rq_wr_rdBar),
    .rq_wdata(rq_wdata), .rq_addr(rq_addr), .rq_done(rq_done), .rq_err(rq_err),
    .rq_rdata(rq_rdata), .m_wdata(m_wdata), .m_target_addr(m_target_addr),
    .m_wr_rdBar(m_wr_rdBar), .m_apb_data_valid(m_apb_data_valid), .m_req(m_req),
    .m_rdata(m_rdata), .m_data_valid(m_data_valid), .m_ready_busyBar(m_ready_busyBar)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  int rr_m = 0;
  bit outstanding = 0;
  int owner = 0;
  int done_cnt = 0;
  int req_cnt = 0;
  int log_q[$];
  logic [N-1:0]  last_done;
  logic [DW-1:0] last_rdata;
  logic          last_err;

  // Master behaviour knobs
  bit            mst_hold = 0;
  bit            mst_dv_en = 0;
  bit            mst_never_busy = 0;
  int            mst_busy_len = 3;
  logic [DW-1:0] mst_rdata_val = '0;
  int            mst_phase = 0;
  int            mst_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int next_grant(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    rq_wr_rdBar[i]     = wr;
    rq_addr[i*AW +: AW] = a;
    rq_wdata[i*DW +: DW] = d;
  endtask

  // One cycle: step to the falling edge and check outputs against the model.
  task automatic tick();
    int g;
    logic [DW-1:0] exp_rd;
    @(negedge clk);
    if (reset) begin
      outstanding = 0;
      rr_m = 0;
    end else begin
      if (m_req || m_apb_data_valid) begin
        g = next_grant(rq_valid, rr_m);
        chk("req_strobes", {m_req, m_apb_data_valid}, 2'b11);
        chk("req_single", outstanding, 0);
        chk("req_has_valid", g >= 0, 1);
        if (g < 0) g = 0;
        chk("req_addr", m_target_addr, rq_addr[g*AW +: AW]);
        chk("req_wdata", m_wdata, rq_wdata[g*DW +: DW]);
        chk("req_wr", m_wr_rdBar, rq_wr_rdBar[g]);
        owner = g;
        outstanding = 1;
        req_cnt++;
      end
      if (rq_done != '0) begin
        exp_rd = (rq_wr_rdBar[owner] || !mst_dv_en || mst_never_busy) ? '0 : mst_rdata_val;
        chk("done_expected", outstanding, 1);
        chk("done_onehot", rq_done, 64'(1) << owner);
        chk("done_rdata", rq_rdata, exp_rd);
        chk("done_err", rq_err, mst_never_busy);
        last_done = rq_done;
        last_rdata = rq_rdata;
        last_err = rq_err;
        log_q.push_back(owner);
        rr_m = (owner + 1) % N;
        outstanding = 0;
        done_cnt++;
      end
    end
  endtask

  task automatic wait_done(input int n, input int budget);
    int start = done_cnt;
    int t = 0;
    while (done_cnt < start + n && t < budget) begin
      tick();
      t++;
    end
    chk("wait_done_count", done_cnt - start, n);
  endtask

  task automatic wait_req(input int budget);
    int t = 0;
    while (!m_req && t < budget) begin
      tick();
      t++;
    end
    chk("wait_req_seen", m_req, 1);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {rq_done, rq_err, rq_rdata, m_wdata, m_target_addr, m_wr_rdBar,
               m_apb_data_valid, m_req}, 0);
  endtask

  // Behavioural I2C master: goes busy after req, optionally returns a byte, then ready.
  initial begin
    m_ready_busyBar = 1'b1;
    m_data_valid = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        mst_phase = 0;
        m_ready_busyBar = !mst_hold;
        m_data_valid = 1'b0;
        m_rdata = '0;
      end else begin
        case (mst_phase)
          0: begin
            m_ready_busyBar = !mst_hold;
            if (m_req && !mst_never_busy) begin
              m_ready_busyBar = 1'b0;
              mst_cnt = mst_busy_len;
              mst_phase = 1;
            end
          end
          1: begin
            if (mst_cnt > 0) mst_cnt--;
            else begin
              if (mst_dv_en) begin
                m_data_valid = 1'b1;
                m_rdata = mst_rdata_val;
              end
              mst_phase = 2;
            end
          end
          default: begin
            m_data_valid = 1'b0;
            m_rdata = '0;
            m_ready_busyBar = 1'b1;
            mst_phase = 0;
          end
        endcase
      end
    end
  end

  initial begin
    int lat;
    int base;
    int r0;
    int d0;
    int exp_order[9] = '{0, 1, 2, 3, 0, 2, 3, 0, 2};
    reset = 1'b1;
    rq_valid = '0;
    rq_wr_rdBar = '0;
    rq_wdata = '0;
    rq_addr = '0;
    #2;
    chk_all_zero("reset_outputs");
    repeat (2) tick();
    reset = 1'b0;

    // Single write
    set_req(0, 1'b1, 7'h50, 8'hA5);
    rq_valid = 4'b0001;
    lat = 0;
    while (!m_req && lat < 20) begin
      tick();
      lat++;
    end
    chk("t1_latency", lat, 2);
    chk("t1_addr", m_target_addr, 7'h50);
    chk("t1_wdata", m_wdata, 8'hA5);
    chk("t1_wr", m_wr_rdBar, 1'b1);
    wait_done(1, 50);
    rq_valid = '0;
    chk("t1_done", last_done, 4'b0001);
    tick();
    chk("idle_payload_zero", {m_target_addr, m_wdata, m_wr_rdBar}, 0);

    // Read with returned byte
    set_req(2, 1'b0, 7'h3C, 8'h00);
    mst_dv_en = 1;
    mst_rdata_val = 8'h7E;
    rq_valid = 4'b0100;
    wait_done(1, 50);
    rq_valid = '0;
    chk("t2_done", last_done, 4'b0100);
    chk("t2_rdata", last_rdata, 8'h7E);
    chk("t2_err", last_err, 1'b0);

    // Write while master strobes data_valid: byte must be ignored
    set_req(1, 1'b1, 7'h22, 8'h5A);
    rq_valid = 4'b0010;
    wait_done(1, 50);
    rq_valid = '0;
    chk("t2b_write_rdata", last_rdata, 8'h00);
    mst_dv_en = 0;

    // Round-robin from a fresh pointer; reads complete without data_valid
    reset = 1'b1;
    #1;
    chk_all_zero("t3_reset_outputs");
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, 7'h10, 8'h01);
    set_req(1, 1'b0, 7'h11, 8'h02);
    set_req(2, 1'b1, 7'h12, 8'h03);
    set_req(3, 1'b0, 7'h13, 8'h04);
    base = log_q.size();
    rq_valid = 4'b1111;
    wait_done(5, 200);
    rq_valid = 4'b1101;
    wait_done(4, 200);
    rq_valid = '0;
    for (int i = 0; i < 9; i++) begin
      if (base + i < log_q.size()) chk("t3_order", log_q[base + i], exp_order[i]);
      else chk("t3_order_missing", base + i, log_q.size());
    end

    // Master not ready at ISSUE
    mst_hold = 1;
    tick();
    tick();
    set_req(3, 1'b1, 7'h11, 8'hC3);
    rq_valid = 4'b1000;
    r0 = req_cnt;
    repeat (10) tick();
    chk("t4_no_req_while_busy", req_cnt - r0, 0);
    mst_hold = 0;
    wait_done(1, 50);
    rq_valid = '0;
    chk("t4_one_req", req_cnt - r0, 1);

    // Reset during WAIT_DONE
    set_req(3, 1'b0, 7'h44, 8'h00);
    mst_busy_len = 20;
    rq_valid = 4'b1000;
    wait_req(20);
    repeat (5) tick();
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    chk_all_zero("t5_reset_outputs");
    rq_valid = '0;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("t5_no_done", done_cnt - d0, 0);
    mst_busy_len = 3;
    set_req(1, 1'b1, 7'h19, 8'h3E);
    rq_valid = 4'b1010;
    wait_req(20);
    chk("t5_grant_addr", m_target_addr, 7'h19);
    wait_done(1, 50);
    rq_valid = '0;
    chk("t5_done", last_done, 4'b0010);

`ifdef I2C_ARB_TIMEOUT_EN
    // Master never goes busy: watchdog fires after 16 cycles in WAIT_BUSY
    mst_never_busy = 1;
    set_req(0, 1'b0, 7'h2A, 8'h00);
    rq_valid = 4'b0001;
    wait_req(20);
    lat = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && lat < 100) begin
      tick();
      lat++;
    end
    rq_valid = '0;
    chk("t6_cycles", lat, 16);
    chk("t6_err", last_err, 1'b1);
    chk("t6_rdata", last_rdata, 8'h00);
    tick();
    mst_never_busy = 0;
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
